// File: rtl/dmem_pkg.sv
// Shared encodings for the dmem_bank data memory: access sizes, clear FSM states,
// error causes and the size/alignment classifier.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SIZE  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    // Classify size/alignment faults; the range check depends on DEPTH and lives in the bank.
    function automatic logic [1:0] err_cause(input logic [1:0] size, input logic [1:0] lane);
        logic [1:0] cause;
        case (size)
            SZ_B:    cause = ERR_NONE;
            SZ_H:    cause = lane[0] ? ERR_ALIGN : ERR_NONE;
            SZ_W:    cause = (lane != 2'b00) ? ERR_ALIGN : ERR_NONE;
            default: cause = ERR_SIZE;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/dmem_bank_if.sv
// Request/response port of the dmem_bank data memory; the MEM stage is the master.
interface dmem_bank_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/data replication and
// load byte/half extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Replicating the store data across lanes lets the byte-enables alone pick the target.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
        endcase
    end

    // Load extraction and extension.
    always_comb begin
        case (lane_i)
            2'd0:    byte_s = rword_i[7:0];
            2'd1:    byte_s = rword_i[15:8];
            2'd2:    byte_s = rword_i[23:16];
            default: byte_s = rword_i[31:24];
        endcase
        half_s = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_B:    rdata_o = unsigned_i ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_H:    rdata_o = unsigned_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_W:    rdata_o = rword_i;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_bank.sv
// RV32I data memory bank: synchronous word array, registered one-cycle responses,
// error reporting and, with DMEM_CLEAR_EN defined, a hardware bulk-clear sequencer.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_bank_if.slave bus,
    input  logic      clr_start,
    output logic      clr_busy,
    output logic      clr_done
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] idx_s;
    logic [1:0]    lane_s;
    logic [1:0]    cause_s;
    logic          err_s;
    logic          accept_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_al_s;
    logic [31:0]   rword_s;
    logic [31:0]   rdata_ext_s;
    logic          clear_we_s;
    logic [AW-1:0] clr_idx_s;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    assign idx_s    = bus.req_addr[AW+1:2];
    assign lane_s   = bus.req_addr[1:0];
    assign cause_s  = (|bus.req_addr[31:AW+2]) ? ERR_RANGE : err_cause(bus.req_size, lane_s);
    assign err_s    = (cause_s != ERR_NONE);
    assign accept_s = bus.req_valid & bus.req_ready;
    assign rword_s  = mem_q[idx_s];

    dmem_lane_align u_align (
        .size_i     (bus.req_size),
        .unsigned_i (bus.req_unsigned),
        .lane_i     (lane_s),
        .wdata_i    (bus.req_wdata),
        .rword_i    (rword_s),
        .be_o       (be_s),
        .wdata_o    (wdata_al_s),
        .rdata_o    (rdata_ext_s)
    );

    // Storage is deliberately not reset, so a reset mid-clear keeps partial progress.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_q[clr_idx_s] <= 32'h0000_0000;
        end else if (accept_s && bus.req_we && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_al_s[8*b +: 8];
                end
            end
        end
    end

    // Next response: data only for error-free loads, zero otherwise.
    always_comb begin
        rsp_valid_d = accept_s;
        rsp_err_d   = accept_s & err_s;
        if (accept_s && !bus.req_we && !err_s) begin
            rsp_rdata_d = rdata_ext_s;
        end else begin
            rsp_rdata_d = 32'h0000_0000;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_CLEAR_EN
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // A clear request wins over a same-cycle access, which is simply not accepted.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        bus.req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = ~clr_start;
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = {AW{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // Clear sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {AW{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign clear_we_s = (state_q == ST_CLEAR);
    assign clr_idx_s  = cnt_q;
    assign clr_busy   = clear_we_s;
    assign clr_done   = done_q;
`else
    logic unused_clr_start_s;

    assign unused_clr_start_s = clr_start;
    assign bus.req_ready      = 1'b1;
    assign clear_we_s         = 1'b0;
    assign clr_idx_s          = {AW{1'b0}};
    assign clr_busy           = 1'b0;
    assign clr_done           = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
// Directed self-checking bench for dmem_bank (DEPTH=16); clear tests follow DMEM_CLEAR_EN.
module tb_dmem_bank;
    import dmem_pkg::*;

    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    logic clr_start;
    logic clr_busy;
    logic clr_done;

    int n_cmp;
    int n_bad;

    dmem_bank_if bus ();

    dmem_bank #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access: present at a negedge, accepted at the next posedge, response checked a half cycle later.
    task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        #1;
        chk({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, ".err"},   {31'd0, bus.rsp_err}, {31'd0, exp_err});
    endtask

    // Silent store used for filling.
    task automatic poke(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_W;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic ready_at_done;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clr_start = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst.valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst.rdata", bus.rsp_rdata, 32'h0);
        chk("rst.err",   {31'd0, bus.rsp_err}, 32'd0);
        chk("rst.busy",  {31'd0, clr_busy}, 32'd0);
        chk("rst.done",  {31'd0, clr_done}, 32'd0);
        rst_n = 1'b1;

        access("sw10", 1'b1, SZ_W, 1'b0, 32'h10, 32'h8000_00FF, 32'h0, 1'b0);
        access("lw10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8000_00FF, 1'b0);

        access("sw10b", 1'b1, SZ_W, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        access("sb13",  1'b1, SZ_B, 1'b0, 32'h13, 32'hFFFF_FFA5, 32'h0, 1'b0);
        access("lb13",  1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFA5, 1'b0);
        access("lbu13", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h0000_00A5, 1'b0);
        access("lw10b", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hA522_3344, 1'b0);
        access("lh12",  1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF_A522, 1'b0);
        access("lhu12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000_A522, 1'b0);
        access("sh10",  1'b1, SZ_H, 1'b0, 32'h10, 32'h7777_BEEF, 32'h0, 1'b0);
        access("lw10c", 1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 32'hA522_BEEF, 1'b0);
        access("lb10",  1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0);
        access("lbu11", 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h0000_00BE, 1'b0);

        // Back-to-back store then load of the same word.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_W;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h1234_5678;
        @(negedge clk);
        bus.req_we = 1'b0;
        chk("b2b.sw.valid", {31'd0, bus.rsp_valid}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b.lw.valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b.lw.rdata", bus.rsp_rdata, 32'h1234_5678);

        access("e.lh11", 1'b0, SZ_H,   1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        access("e.sw12", 1'b1, SZ_W,   1'b0, 32'h12, 32'hDEAD_BEEF, 32'h0, 1'b1);
        access("e.sz11", 1'b0, SZ_RSV, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        access("e.lw40", 1'b0, SZ_W,   1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        access("e.sw40", 1'b1, SZ_W,   1'b0, 32'h40, 32'hDEAD_0000, 32'h0, 1'b1);
        access("e.sb13", 1'b1, SZ_RSV, 1'b0, 32'h13, 32'h0000_0000, 32'h0, 1'b1);
        access("lw10d",  1'b0, SZ_W,   1'b0, 32'h10, 32'h0, 32'hA522_BEEF, 1'b0);
        access("lw00",   1'b0, SZ_W,   1'b0, 32'h00, 32'h0, 32'h1234_5678, 1'b0);
        access("sw3c",   1'b1, SZ_W,   1'b0, 32'h3C, 32'hCAFE_F00D, 32'h0, 1'b0);
        access("lw3c",   1'b0, SZ_W,   1'b0, 32'h3C, 32'h0, 32'hCAFE_F00D, 1'b0);

`ifdef DMEM_CLEAR_EN
        for (int k = 0; k < DEPTH; k++) poke(32'(k * 4), 32'hC0DE_0000 | 32'(k));
        @(negedge clk);
        clr_start = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = SZ_W;
        bus.req_addr = 32'h8;
        bus.req_wdata = 32'h5555_5555;
        #1;
        chk("clr.ready_lo", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        clr_start = 1'b0;
        bus.req_valid = 1'b0;
        chk("clr.no_accept", {31'd0, bus.rsp_valid}, 32'd0);
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        ready_at_done = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_at = i;
                ready_at_done = bus.req_ready;
            end
            @(negedge clk);
        end
        chk("clr.busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        chk("clr.done_pulses", 32'(done_cnt), 32'd1);
        chk("clr.done_cycle",  32'(done_at), 32'(DEPTH));
        chk("clr.ready_at_done", {31'd0, ready_at_done}, 32'd1);
        for (int k = 0; k < DEPTH; k++)
            access($sformatf("clr.w%0d", k), 1'b0, SZ_W, 1'b0, 32'(k * 4), 32'h0, 32'h0, 1'b0);

        // Reset during the sixth clear cycle: words 0..4 already zeroed.
        for (int k = 0; k < DEPTH; k++) poke(32'(k * 4), 32'hBEAD_0000 | 32'(k));
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstclr.busy", {31'd0, clr_busy}, 32'd0);
        done_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (clr_done || clr_busy) done_cnt++;
            @(negedge clk);
        end
        chk("rstclr.quiet", 32'(done_cnt), 32'd0);
        for (int k = 0; k < DEPTH; k++)
            access($sformatf("rstclr.w%0d", k), 1'b0, SZ_W, 1'b0, 32'(k * 4), 32'h0,
                   (k < 5) ? 32'h0 : (32'hBEAD_0000 | 32'(k)), 1'b0);
`else
        @(negedge clk);
        clr_start = 1'b1;
        #1;
        chk("noclr.ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        clr_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (clr_busy || clr_done) busy_cnt++;
            @(negedge clk);
        end
        chk("noclr.quiet", 32'(busy_cnt), 32'd0);
        access("noclr.lw3c", 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 32'hCAFE_F00D, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
